// File: rtl/atom_pkg.sv
// Shared types and encodings for the stateful atom and its packet driver.
// Pure definitions: no logic, no latency, no flow control.
package atom_pkg;

    typedef logic [31:0] int32_t;
    typedef logic [1:0]  int2_t;
    typedef logic        bool;

    localparam int2_t REL_NE = 2'd0;
    localparam int2_t REL_LT = 2'd1;
    localparam int2_t REL_GT = 2'd2;
    localparam int2_t REL_EQ = 2'd3;

    // Zero-vs-zero under "<" is always false, so the atom keeps its state.
    localparam bool   NOP_SEL_1  = 1'b1;
    localparam int2_t NOP_SEL_2  = 2'd2;
    localparam int2_t NOP_OPCODE = REL_LT;

endpackage

// File: rtl/atom_result_fifo.sv
// Synchronous FIFO for atom results; push-to-pop latency one cycle, head shown combinationally.
// No internal backpressure: the caller's credit scheme keeps pushes off a full FIFO.
module atom_result_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       not_empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    assign pop_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && count == CW'(DEPTH)));

endmodule

// File: rtl/atom_pkt_driver.sv
// Feeds registered packet+config to one stateful atom (no-op on idle), returns results at T+3 earliest.
// Upstream ready is a credit check: queued + in-flight results must stay below DEPTH.
module atom_pkt_driver
    import atom_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_in_pkt_1,
    input  logic [W-1:0] i_in_pkt_2,
    input  logic         i_cfg_valid,
    input  logic [W-1:0] i_cfg_cons_1,
    input  logic [W-1:0] i_cfg_cons_2,
    input  bool          i_cfg_sel_1,
    input  int2_t        i_cfg_sel_2,
    input  bool          i_cfg_sel_3,
    input  int2_t        i_cfg_sel_4,
    input  int2_t        i_cfg_rel_opcode,
    output logic [W-1:0] o_pkt_1,
    output logic [W-1:0] o_pkt_2,
    output logic [W-1:0] o_cons_1,
    output logic [W-1:0] o_cons_2,
    output bool          o_sel_1,
    output int2_t        o_sel_2,
    output bool          o_sel_3,
    output int2_t        o_sel_4,
    output int2_t        o_rel_opcode,
    input  logic [W-1:0] i_atom_read,
    input  logic [W-1:0] i_atom_write,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_out_pkt_1,
    output logic [W-1:0] o_out_pkt_2,
    output logic [W-1:0] o_out_read,
    output logic [W-1:0] o_out_write
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [W-1:0] pkt_1;
        logic [W-1:0] pkt_2;
        logic [W-1:0] read;
        logic [W-1:0] write;
    } result_t;

    logic [W-1:0] cfg_cons_1;
    logic [W-1:0] cfg_cons_2;
    bool          cfg_sel_1;
    int2_t        cfg_sel_2;
    bool          cfg_sel_3;
    int2_t        cfg_sel_4;
    int2_t        cfg_rel_opcode;

    logic         accept;
    logic         vld_1;
    logic         vld_2;
    logic [W-1:0] pipe_pkt_1;
    logic [W-1:0] pipe_pkt_2;
    logic [CW-1:0] fifo_count;
    logic [CW:0]  used;
    result_t      push_data;
    result_t      head;

    assign accept = i_in_valid && o_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_cons_1     <= '0;
            cfg_cons_2     <= '0;
            cfg_sel_1      <= 1'b0;
            cfg_sel_2      <= '0;
            cfg_sel_3      <= 1'b0;
            cfg_sel_4      <= '0;
            cfg_rel_opcode <= '0;
        end else if (i_cfg_valid) begin
            cfg_cons_1     <= i_cfg_cons_1;
            cfg_cons_2     <= i_cfg_cons_2;
            cfg_sel_1      <= i_cfg_sel_1;
            cfg_sel_2      <= i_cfg_sel_2;
            cfg_sel_3      <= i_cfg_sel_3;
            cfg_sel_4      <= i_cfg_sel_4;
            cfg_rel_opcode <= i_cfg_rel_opcode;
        end
    end

    // Reset also lands here so the atom sees the no-op while rst is held.
    always_ff @(posedge clk) begin
        if (rst || !accept) begin
            o_pkt_1      <= '0;
            o_pkt_2      <= '0;
            o_cons_1     <= '0;
            o_cons_2     <= '0;
            o_sel_1      <= NOP_SEL_1;
            o_sel_2      <= NOP_SEL_2;
            o_sel_3      <= 1'b0;
            o_sel_4      <= '0;
            o_rel_opcode <= NOP_OPCODE;
        end else begin
            o_pkt_1      <= i_in_pkt_1;
            o_pkt_2      <= i_in_pkt_2;
            o_cons_1     <= cfg_cons_1;
            o_cons_2     <= cfg_cons_2;
            o_sel_1      <= cfg_sel_1;
            o_sel_2      <= cfg_sel_2;
            o_sel_3      <= cfg_sel_3;
            o_sel_4      <= cfg_sel_4;
            o_rel_opcode <= cfg_rel_opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_1      <= 1'b0;
            vld_2      <= 1'b0;
            pipe_pkt_1 <= '0;
            pipe_pkt_2 <= '0;
        end else begin
            vld_1      <= accept;
            vld_2      <= vld_1;
            pipe_pkt_1 <= o_pkt_1;
            pipe_pkt_2 <= o_pkt_2;
        end
    end

    assign used       = {1'b0, fifo_count} + (CW+1)'(vld_1) + (CW+1)'(vld_2);
    assign o_in_ready = (used < (CW+1)'(DEPTH));

    assign push_data = '{pkt_1: pipe_pkt_1, pkt_2: pipe_pkt_2,
                         read: i_atom_read, write: i_atom_write};

    atom_result_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_2),
        .push_data (push_data),
        .pop       (i_out_ready),
        .pop_data  (head),
        .not_empty (o_out_valid),
        .count     (fifo_count)
    );

    assign o_out_pkt_1 = head.pkt_1;
    assign o_out_pkt_2 = head.pkt_2;
    assign o_out_read  = head.read;
    assign o_out_write = head.write;

endmodule

// File: tb/tb_atom_pkt_driver.sv
// Directed bench for atom_pkt_driver with a behavioural read-add-write atom on the atom-facing ports.
module tb_atom_pkt_driver;
    import atom_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_in_valid, o_in_ready;
    logic [W-1:0] i_in_pkt_1, i_in_pkt_2;
    logic         i_cfg_valid;
    logic [W-1:0] i_cfg_cons_1, i_cfg_cons_2;
    logic         i_cfg_sel_1, i_cfg_sel_3;
    logic [1:0]   i_cfg_sel_2, i_cfg_sel_4, i_cfg_rel_opcode;
    logic [W-1:0] o_pkt_1, o_pkt_2, o_cons_1, o_cons_2;
    logic         o_sel_1, o_sel_3;
    logic [1:0]   o_sel_2, o_sel_4, o_rel_opcode;
    logic [W-1:0] i_atom_read, i_atom_write;
    logic         o_out_valid, i_out_ready;
    logic [W-1:0] o_out_pkt_1, o_out_pkt_2, o_out_read, o_out_write;

    always #5 clk = ~clk;

    atom_pkt_driver #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_pkt_1(i_in_pkt_1), .i_in_pkt_2(i_in_pkt_2),
        .i_cfg_valid(i_cfg_valid), .i_cfg_cons_1(i_cfg_cons_1), .i_cfg_cons_2(i_cfg_cons_2),
        .i_cfg_sel_1(i_cfg_sel_1), .i_cfg_sel_2(i_cfg_sel_2), .i_cfg_sel_3(i_cfg_sel_3),
        .i_cfg_sel_4(i_cfg_sel_4), .i_cfg_rel_opcode(i_cfg_rel_opcode),
        .o_pkt_1(o_pkt_1), .o_pkt_2(o_pkt_2), .o_cons_1(o_cons_1), .o_cons_2(o_cons_2),
        .o_sel_1(o_sel_1), .o_sel_2(o_sel_2), .o_sel_3(o_sel_3), .o_sel_4(o_sel_4),
        .o_rel_opcode(o_rel_opcode),
        .i_atom_read(i_atom_read), .i_atom_write(i_atom_write),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_pkt_1(o_out_pkt_1), .o_out_pkt_2(o_out_pkt_2),
        .o_out_read(o_out_read), .o_out_write(o_out_write)
    );

    // Reference atom: pred = rel(sel_1 ? 0 : state, opnd(sel_2)); next = pred ? (sel_3 ? 0 : state) + opnd(sel_4) : state.
    logic [W-1:0] st = '0, a_read = '0, a_write = '0;
    logic [W-1:0] lhs, rhs, base, opnd, nx;
    logic         pred;

    always_comb begin
        lhs = o_sel_1 ? '0 : st;
        case (o_sel_2)
            2'd0:    rhs = o_pkt_1;
            2'd1:    rhs = o_pkt_2;
            2'd2:    rhs = o_cons_1;
            default: rhs = '0;
        endcase
        case (o_rel_opcode)
            2'd0:    pred = (lhs != rhs);
            2'd1:    pred = (lhs < rhs);
            2'd2:    pred = (lhs > rhs);
            default: pred = (lhs == rhs);
        endcase
        base = o_sel_3 ? '0 : st;
        case (o_sel_4)
            2'd0:    opnd = o_pkt_1;
            2'd1:    opnd = o_pkt_2;
            2'd2:    opnd = o_cons_2;
            default: opnd = '0;
        endcase
        nx = pred ? base + opnd : st;
    end

    always @(posedge clk) begin
        st      <= nx;
        a_read  <= st;
        a_write <= nx;
    end

    assign i_atom_read  = a_read;
    assign i_atom_write = a_write;

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [W-1:0] c1, input logic [W-1:0] c2, input logic s1,
                             input logic [1:0] s2, input logic s3, input logic [1:0] s4,
                             input logic [1:0] rel);
        i_cfg_cons_1 = c1; i_cfg_cons_2 = c2;
        i_cfg_sel_1 = s1; i_cfg_sel_2 = s2; i_cfg_sel_3 = s3; i_cfg_sel_4 = s4;
        i_cfg_rel_opcode = rel;
        i_cfg_valid = 1'b1;
        tick();
        i_cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] p1, input logic [W-1:0] p2);
        int n;
        i_in_valid = 1'b1; i_in_pkt_1 = p1; i_in_pkt_2 = p2;
        n = 0;
        while (!o_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!o_in_ready) check("send_timeout", o_in_ready, 1);
        tick();
        i_in_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] p1, input logic [W-1:0] p2,
                              input logic [W-1:0] r, input logic [W-1:0] w);
        int n;
        n = 0;
        while (!o_out_valid && n < 20) begin
            tick();
            n++;
        end
        check({nm, "_valid"}, o_out_valid, 1);
        check({nm, "_pkt"}, {o_out_pkt_1, o_out_pkt_2}, {p1, p2});
        check({nm, "_read"}, o_out_read, r);
        check({nm, "_write"}, o_out_write, w);
        tick();
    endtask

    logic [135:0] nop_exp;
    function automatic logic [135:0] facing();
        return {o_pkt_1, o_pkt_2, o_cons_1, o_cons_2, o_sel_1, o_sel_2, o_sel_3, o_sel_4, o_rel_opcode};
    endfunction

    typedef struct {
        logic         cfg_wr;
        logic [W-1:0] cons_1, cons_2;
        logic         sel_1, sel_3;
        logic [1:0]   sel_2, sel_4, rel;
        logic [W-1:0] p1, p2, exp_read, exp_write;
    } vec_t;
    vec_t tbl[7];

    logic [127:0] expq[$];
    bit           mon_en = 1'b0;
    int           nrecv = 0;

    always @(negedge clk) begin
        if (mon_en && o_out_valid && i_out_ready) begin
            logic [127:0] e;
            nrecv++;
            e = (expq.size() != 0) ? expq.pop_front() : '1;
            check("stream_item", {o_out_pkt_1, o_out_pkt_2, o_out_read, o_out_write}, e);
        end
    end

    initial begin
        logic [W-1:0] st_exp;
        logic [W-1:0] r;
        int nacc, idx, lat, seen;

        nop_exp = {128'd0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd1};
        //            wr    cons_1        cons_2  s1    s3    s2    s4    rel   p1     p2             read   write
        tbl[0] = '{1'b1, 32'd0,  32'd0,  1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 32'd5,  32'd7,          32'd0,  32'd7};
        tbl[1] = '{1'b0, 32'd0,  32'd0,  1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 32'd5,  32'd7,          32'd7,  32'd7};
        tbl[2] = '{1'b1, 32'd4,  32'd50, 1'b1, 1'b1, 2'd2, 2'd2, 2'd2, 32'd1,  32'd1,          32'd7,  32'd7};
        tbl[3] = '{1'b1, 32'd0,  32'd50, 1'b0, 1'b1, 2'd1, 2'd2, 2'd2, 32'd1,  32'd6,          32'd7,  32'd50};
        tbl[4] = '{1'b1, 32'd50, 32'd0,  1'b0, 1'b0, 2'd2, 2'd0, 2'd3, 32'd10, 32'd0,          32'd50, 32'd60};
        tbl[5] = '{1'b1, 32'd0,  32'd0,  1'b0, 1'b0, 2'd3, 2'd1, 2'd0, 32'd1,  32'hFFFF_FFFF,  32'd60, 32'd59};
        tbl[6] = '{1'b1, 32'd0,  32'd0,  1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 32'd0,  32'd5,          32'd59, 32'd59};

        rst = 1'b1; i_in_valid = 1'b0; i_in_pkt_1 = '0; i_in_pkt_2 = '0;
        i_cfg_valid = 1'b0; i_cfg_cons_1 = '0; i_cfg_cons_2 = '0;
        i_cfg_sel_1 = 1'b0; i_cfg_sel_2 = '0; i_cfg_sel_3 = 1'b0; i_cfg_sel_4 = '0;
        i_cfg_rel_opcode = '0; i_out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            check("idle_ready", o_in_ready, 1);
            check("idle_out_valid", o_out_valid, 0);
            check("idle_nop", facing(), nop_exp);
            tick();
        end
        check("idle_atom_state", st, 0);

        for (int v = 0; v < 7; v++) begin
            if (tbl[v].cfg_wr)
                write_cfg(tbl[v].cons_1, tbl[v].cons_2, tbl[v].sel_1, tbl[v].sel_2,
                          tbl[v].sel_3, tbl[v].sel_4, tbl[v].rel);
            send(tbl[v].p1, tbl[v].p2);
            lat = 1;
            while (!o_out_valid && lat < 10) begin
                tick();
                lat++;
            end
            check("vec_latency", lat, 3);
            expect_out("vec", tbl[v].p1, tbl[v].p2, tbl[v].exp_read, tbl[v].exp_write);
        end
        st_exp = 32'd59;

        // Accumulate mode: state += pkt_2 whenever pkt_2 != 0.
        write_cfg(0, 0, 1'b1, 2'd1, 1'b0, 2'd1, REL_NE);
        i_out_ready = 1'b0;
        nacc = 0;
        for (int k = 0; k < 6; k++) begin
            i_in_valid = 1'b1; i_in_pkt_1 = 100 + nacc; i_in_pkt_2 = nacc + 1;
            if (o_in_ready) nacc++;
            tick();
        end
        i_in_valid = 1'b0;
        check("bp_accepted", nacc, 4);
        repeat (3) tick();
        check("bp_ready_low", o_in_ready, 0);
        i_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            r = st_exp; st_exp = st_exp + k + 1;
            expect_out("bp_drain", 100 + k, k + 1, r, st_exp);
        end
        check("bp_ready_resume", o_in_ready, 1);
        for (int k = 4; k < 6; k++) begin
            send(100 + k, k + 1);
            r = st_exp; st_exp = st_exp + k + 1;
            expect_out("bp_resume", 100 + k, k + 1, r, st_exp);
        end

        mon_en = 1'b1;
        idx = 0;
        for (int c = 0; c < 300 && !(idx == 12 && nrecv == 12); c++) begin
            if (idx < 12) begin
                i_in_valid = 1'b1; i_in_pkt_1 = 200 + idx; i_in_pkt_2 = idx + 1;
                if (o_in_ready) begin
                    r = st_exp; st_exp = st_exp + idx + 1;
                    expq.push_back({32'(200 + idx), 32'(idx + 1), r, st_exp});
                    idx++;
                end
            end else begin
                i_in_valid = 1'b0;
            end
            i_out_ready = ~i_out_ready;
            tick();
        end
        i_in_valid = 1'b0;
        i_out_ready = 1'b1;
        mon_en = 1'b0;
        check("stream_count", nrecv, 12);
        check("stream_left", expq.size(), 0);

        // Zero the atom state, then race a config write against packet A.
        write_cfg(1, 0, 1'b1, 2'd2, 1'b1, 2'd3, REL_LT);
        send(0, 0);
        expect_out("zero", 0, 0, st_exp, 0);
        i_cfg_cons_1 = 0; i_cfg_cons_2 = 100;
        i_cfg_sel_1 = 1'b0; i_cfg_sel_2 = 2'd0; i_cfg_sel_3 = 1'b0; i_cfg_sel_4 = 2'd2;
        i_cfg_rel_opcode = REL_EQ; i_cfg_valid = 1'b1;
        i_in_valid = 1'b1; i_in_pkt_1 = 0; i_in_pkt_2 = 5;
        check("race_ready", o_in_ready, 1);
        tick();
        i_cfg_valid = 1'b0; i_in_valid = 1'b0;
        send(0, 5);
        expect_out("race_a_oldcfg", 0, 5, 0, 0);
        expect_out("race_b_newcfg", 0, 5, 0, 100);

        // Four packets in flight/queued, then reset; the packet in the atom-facing
        // registers is absorbed on the edge that samples rst, so state ends at 100+1+2+3+4.
        write_cfg(0, 0, 1'b1, 2'd1, 1'b0, 2'd1, REL_NE);
        i_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_in_valid = 1'b1; i_in_pkt_1 = 300 + k; i_in_pkt_2 = k + 1;
            tick();
        end
        i_in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_nop", facing(), nop_exp);
        check("rst_out_valid", o_out_valid, 0);
        rst = 1'b0;
        i_out_ready = 1'b1;
        check("rst_ready", o_in_ready, 1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_out_valid) seen++;
            tick();
        end
        check("rst_no_output", seen, 0);
        check("rst_atom_state", st, 110);

        // Config is back to zero: pred = state != pkt_1, write = state + pkt_1.
        send(5, 0);
        expect_out("post_rst_cfg", 5, 0, 110, 115);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
